// File: rtl/alu_decode_pkg.sv
// Shared constants for the ALU decoder: control-word encodings, ALUOP classes,
// M-extension selectors and the controller state type.
package alu_decode_pkg;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_MDU  = 4'b1111;

    localparam logic [1:0] ALUOP_LS  = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_RI  = 2'b10;
    localparam logic [1:0] ALUOP_RSV = 2'b11;

    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide: one bit per cycle on operand magnitudes, signs
// restored when the last iteration retires.
module mdu_iter import alu_decode_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [XLEN-1:0] hi, lo, dv, a_raw;
    logic            neg_a, neg_b, b_zero;

    logic            sa, sb, na, nb;
    logic [XLEN-1:0] aa, bb, nhi, nlo, q, r, fix;
    logic [XLEN:0]   msum, dshift, dsub;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        sa = (op == M_MULH) || (op == M_MULHSU) || (op == M_DIV) || (op == M_REM);
        sb = (op == M_MULH) || (op == M_DIV) || (op == M_REM);
        na = sa & a[XLEN-1];
        nb = sb & b[XLEN-1];
        aa = na ? -a : a;
        bb = nb ? -b : b;
    end

    // hi:lo is the product accumulator for multiply, remainder:quotient for divide
    always_comb begin
        msum   = {1'b0, hi} + (lo[0] ? {1'b0, dv} : '0);
        dshift = {hi, lo[XLEN-1]};
        dsub   = dshift - {1'b0, dv};
        if (op_q[2]) begin
            if (!dsub[XLEN]) begin
                nhi = dsub[XLEN-1:0];
                nlo = {lo[XLEN-2:0], 1'b1};
            end else begin
                nhi = dshift[XLEN-1:0];
                nlo = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            nhi = msum[XLEN:1];
            nlo = {msum[0], lo[XLEN-1:1]};
        end
    end

    always_comb begin
        prod = {nhi, nlo};
        q    = nlo;
        r    = nhi;
        if (neg_a ^ neg_b) begin
            prod = -prod;
            q    = -q;
        end
        if (neg_a) r = -r;
        if (b_zero) begin
            q = '1;
            r = a_raw;
        end
        case (op_q)
            M_MUL:                      fix = prod[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU:  fix = prod[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:              fix = q;
            default:                    fix = r;
        endcase
    end

    assign done = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_q   <= '0;
            hi     <= '0;
            lo     <= '0;
            dv     <= '0;
            a_raw  <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_zero <= 1'b0;
            result <= '0;
        end else if (start) begin
            cnt    <= CW'(XLEN);
            op_q   <= op;
            hi     <= '0;
            lo     <= op[2] ? aa : bb;
            dv     <= op[2] ? bb : aa;
            a_raw  <= a;
            neg_a  <= na;
            neg_b  <= nb;
            b_zero <= (b == '0);
        end else if (cnt != '0) begin
            hi  <= nhi;
            lo  <= nlo;
            cnt <= cnt - CW'(1);
            if (done) result <= fix;
        end
    end
endmodule

// File: rtl/alu_decode_mdu.sv
// ALU control decoder with handshaked output registers; M-extension ops are
// routed through the iterative MDU while the pipeline stalls.
module alu_decode_mdu import alu_decode_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOP,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            op5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] mdu_result
);
    state_t          state, state_nx;
    logic [3:0]      dec_ctrl, ctrl_q;
    logic            dec_m, m_q, accept, mdu_done;
    logic [XLEN-1:0] mdu_res;

    always_comb begin
        dec_ctrl = ALU_ADD;
        dec_m    = 1'b0;
        case (ALUOP)
            ALUOP_BR: begin
                case (funct3[2:1])
                    2'b00:   dec_ctrl = ALU_SUB;
                    2'b10:   dec_ctrl = ALU_SLT;
                    2'b11:   dec_ctrl = ALU_SLTU;
                    default: dec_ctrl = ALU_ADD;
                endcase
            end
            ALUOP_RI: begin
                if (op5 && funct7 == F7_MEXT) begin
                    dec_ctrl = ALU_MDU;
                    dec_m    = 1'b1;
                end else begin
                    case (funct3)
                        3'b000:  dec_ctrl = (op5 && funct7[5]) ? ALU_SUB : ALU_ADD;
                        3'b001:  dec_ctrl = ALU_SLL;
                        3'b010:  dec_ctrl = ALU_SLT;
                        3'b011:  dec_ctrl = ALU_SLTU;
                        3'b100:  dec_ctrl = ALU_XOR;
                        3'b101:  dec_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  dec_ctrl = ALU_OR;
                        default: dec_ctrl = ALU_AND;
                    endcase
                end
            end
            default: dec_ctrl = ALU_ADD;
        endcase
    end

    assign in_ready = (state == S_IDLE);
    assign accept   = in_ready && in_valid;

    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && dec_m),
        .op     (funct3),
        .a      (src_a),
        .b      (src_b),
        .done   (mdu_done),
        .result (mdu_res)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_valid) state_nx = dec_m ? S_CALC : S_DONE;
            S_CALC:  if (mdu_done) state_nx = S_DONE;
            S_DONE:  if (out_valid && out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs load on the first DONE cycle and hold until the consumer takes them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ctrl_q      <= ALU_ADD;
            m_q         <= 1'b0;
            out_valid   <= 1'b0;
            alu_control <= ALU_ADD;
            mdu_result  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                ctrl_q <= dec_ctrl;
                m_q    <= dec_m;
            end
            if (state == S_DONE && !out_valid) begin
                out_valid   <= 1'b1;
                alu_control <= ctrl_q;
                mdu_result  <= m_q ? mdu_res : '0;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_decode_mdu.sv
// Directed bench for alu_decode_mdu: decode table, M-op results and latency,
// backpressure hold and reset in the middle of an iteration.
module tb_alu_decode_mdu;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, op5, out_valid, out_ready;
    logic [1:0]  ALUOP;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] src_a, src_b, mdu_result;
    logic [3:0]  alu_control;
    int          passed = 0, total = 0, lat;

    always #5 clk = ~clk;

    alu_decode_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOP(ALUOP), .funct3(funct3), .funct7(funct7), .op5(op5),
        .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .mdu_result(mdu_result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic run(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                       input logic o5, input logic [31:0] a, input logic [31:0] b,
                       output int l);
        @(negedge clk);
        ALUOP = aop; funct3 = f3; funct7 = f7; op5 = o5; src_a = a; src_b = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        l = 0;
        while (!out_valid && l < 100) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic op_chk(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                          input logic [6:0] f7, input logic o5, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] ectrl,
                          input logic [31:0] eres, input int elat);
        int l;
        run(aop, f3, f7, o5, a, b, l);
        chk({tag, "_lat"}, l, elat);
        chk({tag, "_ctrl"}, {28'd0, alu_control}, {28'd0, ectrl});
        chk({tag, "_res"}, mdu_result, eres);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ALUOP = 2'b00; funct3 = 3'b000; funct7 = 7'd0; op5 = 1'b0;
        src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ctrl", {28'd0, alu_control}, 32'd0);
        chk("rst_res", mdu_result, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        op_chk("r_sub",  2'b10, 3'b000, 7'h20, 1'b1, 32'd0, 32'd0, 4'b0010, 32'd0, 1);
        op_chk("r_sra",  2'b10, 3'b101, 7'h20, 1'b1, 32'd0, 32'd0, 4'b1101, 32'd0, 1);
        op_chk("i_add",  2'b10, 3'b000, 7'h20, 1'b0, 32'd0, 32'd0, 4'b0000, 32'd0, 1);
        op_chk("r_srl",  2'b10, 3'b101, 7'h00, 1'b1, 32'd0, 32'd0, 4'b0101, 32'd0, 1);
        op_chk("br_slt", 2'b01, 3'b100, 7'h00, 1'b0, 32'd0, 32'd0, 4'b1011, 32'd0, 1);
        op_chk("br_sltu",2'b01, 3'b111, 7'h00, 1'b0, 32'd0, 32'd0, 4'b1001, 32'd0, 1);
        op_chk("br_sub", 2'b01, 3'b001, 7'h00, 1'b0, 32'd0, 32'd0, 4'b0010, 32'd0, 1);
        op_chk("rsv_add",2'b11, 3'b111, 7'h20, 1'b1, 32'd0, 32'd0, 4'b0000, 32'd0, 1);

        op_chk("mulh",   2'b10, 3'b001, 7'h01, 1'b1, 32'hFFFFFFFF, 32'h2, 4'b1111, 32'hFFFFFFFF, 33);
        op_chk("mul",    2'b10, 3'b000, 7'h01, 1'b1, 32'hFFFFFFFF, 32'h2, 4'b1111, 32'hFFFFFFFE, 33);
        op_chk("mulhu",  2'b10, 3'b011, 7'h01, 1'b1, 32'hFFFFFFFF, 32'h2, 4'b1111, 32'h00000001, 33);
        op_chk("div",    2'b10, 3'b100, 7'h01, 1'b1, 32'hFFFFFFF9, 32'h2, 4'b1111, 32'hFFFFFFFD, 33);
        op_chk("rem",    2'b10, 3'b110, 7'h01, 1'b1, 32'hFFFFFFF9, 32'h2, 4'b1111, 32'hFFFFFFFF, 33);
        op_chk("divu_z", 2'b10, 3'b101, 7'h01, 1'b1, 32'h00001234, 32'h0, 4'b1111, 32'hFFFFFFFF, 33);
        op_chk("remu_z", 2'b10, 3'b111, 7'h01, 1'b1, 32'h5, 32'h0, 4'b1111, 32'h5, 33);
        op_chk("div_ovf",2'b10, 3'b100, 7'h01, 1'b1, 32'h80000000, 32'hFFFFFFFF, 4'b1111, 32'h80000000, 33);
        op_chk("rem_ovf",2'b10, 3'b110, 7'h01, 1'b1, 32'h80000000, 32'hFFFFFFFF, 4'b1111, 32'h0, 33);

        // Backpressure: XOR held in DONE while an AND is offered
        out_ready = 1'b0;
        run(2'b10, 3'b100, 7'h00, 1'b1, 32'd0, 32'd0, lat);
        chk("bp_lat", lat, 1);
        @(negedge clk);
        funct3 = 3'b111; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_ctrl", {28'd0, alu_control}, 32'h4);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_rel_ctrl", {28'd0, alu_control}, 32'h4);

        // Reset during the multiply iterations
        @(negedge clk);
        ALUOP = 2'b10; funct3 = 3'b000; funct7 = 7'h01; op5 = 1'b1;
        src_a = 32'h7; src_b = 32'h9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_ctrl", {28'd0, alu_control}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        op_chk("post_rst_add", 2'b00, 3'b000, 7'h00, 1'b0, 32'd0, 32'd0, 4'b0000, 32'd0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
